pipe_stage_skid: RTL

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_pkg.sv | 30 +++
 rtl/pipe_stage_skid_entry_reg.sv | 48 ++++
 rtl/pipe_stage_skid.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_pkg
// Purpose  : Shared state encoding and control-bit indices for the
//            EX/MEM two-entry skid buffer stage.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_skid_pkg;

  // Occupancy states; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Bit positions inside the control field of an entry.
  localparam int unsigned c_HALT        = 0;
  localparam int unsigned c_MEMREAD     = 1;
  localparam int unsigned c_MEMWRITE    = 2;
  localparam int unsigned c_REGWRITE    = 3;
  localparam int unsigned c_TOWRITEDATA = 4;
  localparam int unsigned c_MEMTOREG    = 5;
  localparam int unsigned c_JUMP        = 6;
  localparam int unsigned c_BRANCH      = 7;
  localparam int unsigned c_JALR        = 8;
  localparam int unsigned c_NUM_CTRL    = 9;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_entry_reg.sv
`default_nettype none
// ============================================================================
// Module   : skid_entry_reg
// Purpose  : One pipeline entry register (data, ctrl, rd) with a load
//            enable and a synchronous clear that wins over the load.
// Revision : 1.0 - initial release
// ============================================================================
module skid_entry_reg
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = c_NUM_CTRL,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [RD_W-1:0]   rd_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [RD_W-1:0]   rd_q;

  // Entry storage: clear zeroes the entry, otherwise load captures the input.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      data_q <= '0;
      ctrl_q <= '0;
      rd_q   <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
      rd_q   <= rd_i;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;
  assign rd_o   = rd_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Two-entry skid buffer carrying the EX/MEM pipeline fields.
//            in_ready is registered so there is no combinational path from
//            out_ready back to the upstream stage.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NDATA  = 4,
  parameter int CTRL_W = 9,
  parameter int RD_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [RD_W-1:0]         in_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [RD_W-1:0]         out_rd,
  output logic [1:0]              count
);

  localparam int c_WORD_W = NDATA * DATA_W;

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;

  logic push, pop;
  logic head_load, skid_load, head_from_skid;

  logic [c_WORD_W-1:0] head_data, skid_data, head_din_data;
  logic [CTRL_W-1:0]   head_ctrl, skid_ctrl, head_din_ctrl;
  logic [RD_W-1:0]     head_rd,   skid_rd,   head_din_rd;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  // Next-state and entry-load decode; flush overrides any push or pop.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            head_load = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (push && pop) begin
            head_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  // State and registered ready; reset beats flush, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Head refills from skid on a FULL pop so arrival order is preserved.
  assign head_din_data = head_from_skid ? skid_data : in_data;
  assign head_din_ctrl = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_din_rd   = head_from_skid ? skid_rd   : in_rd;

  skid_entry_reg #(
    .DATA_W (c_WORD_W),
    .CTRL_W (CTRL_W),
    .RD_W   (RD_W)
  ) u_head (
    .clk     (clk),
    .clear_i (rst),
    .load_i  (head_load),
    .data_i  (head_din_data),
    .ctrl_i  (head_din_ctrl),
    .rd_i    (head_din_rd),
    .data_o  (head_data),
    .ctrl_o  (head_ctrl),
    .rd_o    (head_rd)
  );

  skid_entry_reg #(
    .DATA_W (c_WORD_W),
    .CTRL_W (CTRL_W),
    .RD_W   (RD_W)
  ) u_skid (
    .clk     (clk),
    .clear_i (rst),
    .load_i  (skid_load),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .rd_i    (in_rd),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl),
    .rd_o    (skid_rd)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign count     = state_q;
  assign out_data  = head_data;
  assign out_rd    = head_rd;
  // Bubbles must never carry MEMWRITE/REGWRITE downstream.
  assign out_ctrl  = out_valid ? head_ctrl : '0;

endmodule
`default_nettype wire
